alu_exec_unit: RTL and testbench

Execute-stage consumer of the 5-bit ALU operation code and `Sign` bit produced by the ALU control decoder. It accepts operand pairs plus op code over a valid/ready handshake, computes the result, and presents it through a registered output with a one-entry skid buffer. This lets the EX stage absorb MEM-side back-pressure without losing an issued instruction. It sits between ID/EX operand selection and the EX/MEM register.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_core.sv | 67 ++++++
 rtl/alu_exec_unit.sv | 116 +++++++++++
 tb/tb_alu_exec_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU op-code constants and execute-unit occupancy states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_CTRL_W = 5;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 5'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 5'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 5'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 5'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 5'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 5'd5;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 5'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 5'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 5'd8;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 5'd9;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
//  Module      : alu_core
//  Description : Combinational ALU producing result, zero, overflow, illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [ALU_CTRL_W-1:0] op_i,
    input  logic                  sign_i,
    input  logic [WIDTH-1:0]      a_i,
    input  logic [WIDTH-1:0]      b_i,
    output logic [WIDTH-1:0]      result_o,
    output logic                  zero_o,
    output logic                  overflow_o,
    output logic                  illegal_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;

    assign w_shamt = a_i[SHW-1:0];
    assign w_sum   = a_i + b_i;
    assign w_diff  = a_i - b_i;
    assign w_lt    = sign_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        illegal_o  = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o   = w_sum;
                overflow_o = sign_i && (a_i[WIDTH-1] == b_i[WIDTH-1])
                                    && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                result_o   = w_diff;
                overflow_o = sign_i && (a_i[WIDTH-1] != b_i[WIDTH-1])
                                    && (w_diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_SLL: result_o = b_i << w_shamt;
            ALU_SRL: result_o = b_i >> w_shamt;
            // Arithmetic shift ignores Sign: SRA is always signed.
            ALU_SRA: result_o = $signed(b_i) >>> w_shamt;
            ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, w_lt};
            default: illegal_o = 1'b1;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule : alu_core

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Execute-stage ALU with valid/ready handshake and skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_CTRL_W-1:0] ALUCtrl,
    input  logic                  Sign,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
    output logic                  out_zero,
    output logic                  out_overflow,
    output logic                  out_illegal
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             overflow;
        logic             illegal;
    } payload_t;

    occ_state_e state_q, state_d;
    logic       in_ready_q, in_ready_d;
    payload_t   out_q, out_d;
    payload_t   skid_q, skid_d;
    payload_t   w_core;
    logic       w_in_fire;
    logic       w_out_fire;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op_i       (ALUCtrl),
        .sign_i     (Sign),
        .a_i        (in_a),
        .b_i        (in_b),
        .result_o   (w_core.result),
        .zero_o     (w_core.zero),
        .overflow_o (w_core.overflow),
        .illegal_o  (w_core.illegal)
    );

    assign w_in_fire  = in_valid && in_ready_q;
    assign w_out_fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            OCC_EMPTY: begin
                if (w_in_fire) begin
                    out_d   = w_core;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (w_in_fire && !w_out_fire) begin
                    skid_d  = w_core;
                    state_d = OCC_FULL;
                end else if (w_in_fire && w_out_fire) begin
                    out_d   = w_core;
                end else if (w_out_fire) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (w_out_fire) begin
                    out_d   = skid_q;
                    state_d = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        // Registered ready: derived from next occupancy, never from out_ready directly.
        in_ready_d = (state_d != OCC_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (state_q != OCC_EMPTY);
    assign out_result   = out_q.result;
    assign out_zero     = out_q.zero;
    assign out_overflow = out_q.overflow;
    assign out_illegal  = out_q.illegal;

endmodule : alu_exec_unit

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Self-checking bench for alu_exec_unit with a FIFO scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         o;
        logic         il;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   ALUCtrl;
    logic         Sign;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_overflow;
    logic         out_illegal;

    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ALUCtrl      (ALUCtrl),
        .Sign         (Sign),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU evaluated with wide signed/unsigned integer arithmetic.
    function automatic exp_t ref_alu(input logic [4:0] op, input logic sg,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, ua, ub, wide;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(a % 32);
        e  = '0;
        case (op)
            5'd0: begin
                wide  = sa + sb;
                e.res = W'(ua + ub);
                e.o   = sg && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
            end
            5'd1: begin
                wide  = sa - sb;
                e.res = W'(ua - ub);
                e.o   = sg && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
            end
            5'd2: e.res = a & b;
            5'd3: e.res = a | b;
            5'd4: e.res = a ^ b;
            5'd5: e.res = ~(a | b);
            5'd6: e.res = W'(ub << sh);
            5'd7: e.res = W'(ub >> sh);
            5'd8: e.res = W'(sb >>> sh);
            5'd9: e.res = (sg ? (sa < sb) : (ua < ub)) ? 32'd1 : 32'd0;
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    // Called at a negedge: drive, compare against the model, advance one cycle.
    task automatic step(input logic v, input logic [4:0] op, input logic sg,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
        logic in_fire, out_fire;
        exp_t e;
        in_valid  = v;
        ALUCtrl   = op;
        Sign      = sg;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        check_eq("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
        check_eq("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
        if (sb_q.size() > 0)
            check_eq("payload", {28'd0, out_result, out_zero, out_overflow, out_illegal},
                     {28'd0, sb_q[0]});
        in_fire  = v && (sb_q.size() < 2);
        out_fire = ordy && (sb_q.size() > 0);
        e = ref_alu(op, sg, a, b);
        @(posedge clk);
        if (out_fire) void'(sb_q.pop_front());
        if (in_fire) sb_q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        logic [W-1:0] edge_v [5];
        edge_v = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
        if ($urandom_range(0, 3) == 0) return edge_v[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic step_rand(input logic v, input logic ordy);
        logic [4:0] op;
        op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
        step(v, op, 1'($urandom), rnd_opnd(), rnd_opnd(), ordy);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        ALUCtrl   = '0;
        Sign      = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", 64'(out_result), 64'd0);
        check_eq("rst_flags", {61'd0, out_zero, out_overflow, out_illegal}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed corner cases, one result visible per step.
        step(1'b1, 5'd0, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b1);
        check_eq("add_s_res", 64'(out_result), 64'h8000_0000);
        check_eq("add_s_ovf", 64'(out_overflow), 64'd1);
        check_eq("add_s_zero", 64'(out_zero), 64'd0);
        step(1'b1, 5'd0, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b1);
        check_eq("add_u_ovf", 64'(out_overflow), 64'd0);
        step(1'b1, 5'd9, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1);
        check_eq("slt_s", 64'(out_result), 64'd1);
        step(1'b1, 5'd9, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        check_eq("slt_u", 64'(out_result), 64'd0);
        step(1'b1, 5'd8, 1'b0, 32'h4, 32'h8000_0000, 1'b1);
        check_eq("sra", 64'(out_result), 64'hF800_0000);
        step(1'b1, 5'd1, 1'b1, 32'h1234, 32'h1234, 1'b1);
        check_eq("sub_zero", {31'd0, out_result, out_zero}, 64'd1);
        step(1'b1, 5'd12, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1);
        check_eq("illegal", {29'd0, out_result, out_zero, out_overflow, out_illegal}, 64'b101);
        step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Back-pressure: X then Y held, then drained in order.
        step(1'b1, 5'd3, 1'b0, 32'hF0, 32'h0F, 1'b0);
        step(1'b1, 5'd4, 1'b0, 32'hFF, 32'h0F, 1'b0);
        check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
        check_eq("bp_x_held", 64'(out_result), 64'hFF);
        step(1'b1, 5'd0, 1'b0, 32'h5, 32'h5, 1'b0);
        check_eq("bp_x_stable", 64'(out_result), 64'hFF);
        step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("bp_y_out", 64'(out_result), 64'hF0);
        check_eq("bp_in_ready_back", 64'(in_ready), 64'd1);
        step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Streaming: 100 back-to-back ops with no bubbles.
        for (int i = 0; i < 100; i++) step_rand(1'b1, 1'b1);
        step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Random handshake traffic.
        for (int i = 0; i < 300; i++) step_rand(1'($urandom), 1'($urandom));

        // Reset while FULL.
        while (sb_q.size() > 0) step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 5'd2, 1'b0, 32'hFF, 32'hF0, 1'b0);
        step(1'b1, 5'd3, 1'b0, 32'h1, 32'h2, 1'b0);
        check_eq("full_before_rst", 64'(in_ready), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        check_eq("arst_result", 64'(out_result), 64'd0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++) step_rand(1'b1, 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_exec_unit

`default_nettype wire
